// File: rtl/sdram_wr_burst_pkg.sv
// Shared definitions for the SDRAM write-burst collector. The state encoding
// and the default burst geometry are also used by the ftdi front end.
package sdram_wr_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REQ     = 2'd2,
        ST_XFER    = 2'd3
    } wr_state_e;

    localparam int WRB_BURST_LEN     = 8;
    localparam int WRB_FLUSH_TIMEOUT = 64;

    // Index width for an n-entry buffer, never narrower than one bit.
    function automatic int wrb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_wr_burst_buf.sv
// Burst word store: BURST_LEN x DW register file, one write port and one
// combinational read port. Contents are deliberately not reset; the owner
// tracks validity with its word count.
module wr_burst_buf
    import sdram_wr_burst_pkg::*;
#(
    parameter int DW        = 16,
    parameter int BURST_LEN = WRB_BURST_LEN,
    parameter int IW        = wrb_idx_width(BURST_LEN)
) (
    input  logic          mem_clk,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [BURST_LEN];

    // Storage write: one word per capture cycle.
    always_ff @(posedge mem_clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read of the addressed word.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/sdram_wr_burst.sv
// SDRAM write-burst collector. Accepts single-word writes from upstream,
// gathers address-contiguous words into a buffer and hands them to the SDRAM
// controller as one burst. A burst is launched when the buffer is full, when
// a non-contiguous write arrives, or after an idle timeout.
module sdram_wr_burst
    import sdram_wr_burst_pkg::*;
#(
    parameter int AW            = 25,
    parameter int DW            = 16,
    parameter int BURST_LEN     = WRB_BURST_LEN,
    parameter int FLUSH_TIMEOUT = WRB_FLUSH_TIMEOUT
) (
    input  logic                         mem_clk,
    input  logic                         ft_reset,
    input  logic                         mem_wr_req,
    input  logic [AW-1:0]                mem_wr_addr,
    input  logic [DW-1:0]                mem_wr_data,
    output logic                         mem_ack,
    output logic                         mem_data_next,
    output logic                         mem_idle,
    output logic                         sd_req,
    output logic [AW-1:0]                sd_addr,
    output logic [$clog2(BURST_LEN):0]   sd_len,
    input  logic                         sd_gnt,
    input  logic                         sd_wdata_next,
    output logic [DW-1:0]                sd_wdata
);

    localparam int LW = $clog2(BURST_LEN) + 1;
    localparam int IW = wrb_idx_width(BURST_LEN);
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

    wr_state_e     state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] to_q, to_d;
    logic [AW-1:0] base_q, base_d;

    logic          ack_q, ack_d;
    logic          dn_q, dn_d;
    logic          sd_req_q, sd_req_d;
    logic [AW-1:0] sd_addr_q, sd_addr_d;
    logic [LW-1:0] sd_len_q, sd_len_d;
    logic [DW-1:0] sd_wdata_q, sd_wdata_d;
    logic          idle_q, idle_d;

    logic          contig_s;
    logic          can_take_s;
    logic          flush_s;
    logic          last_s;
    logic [DW-1:0] buf_rdata_s;

    // Word buffer; written in the data-capture cycle, read at the index the
    // burst will present next so sd_wdata can be registered.
    wr_burst_buf #(
        .DW        (DW),
        .BURST_LEN (BURST_LEN),
        .IW        (IW)
    ) u_buf (
        .mem_clk (mem_clk),
        .we_i    (dn_q),
        .waddr_i (count_q[IW-1:0]),
        .wdata_i (mem_wr_data),
        .raddr_i (idx_d),
        .rdata_o (buf_rdata_s)
    );

    // Accept / flush decisions. Address arithmetic wraps modulo 2^AW, so a
    // burst may straddle the top of the address space. No flush is taken
    // while an accepted word is still in flight.
    always_comb begin
        contig_s   = (mem_wr_addr == (base_q + AW'(count_q)));
        can_take_s = mem_wr_req
                     && ((state_q == ST_IDLE) || (state_q == ST_COLLECT))
                     && !ack_q && !dn_q
                     && (count_q < LW'(BURST_LEN))
                     && ((count_q == {LW{1'b0}}) || contig_s);
        if (state_q == ST_COLLECT) begin
            flush_s = (count_q == LW'(BURST_LEN))
                      || (!ack_q && !dn_q && (count_q != {LW{1'b0}})
                          && ((mem_wr_req && !contig_s)
                              || (to_q == TW'(FLUSH_TIMEOUT))));
        end else begin
            flush_s = 1'b0;
        end
        last_s = (state_q == ST_XFER) && sd_wdata_next
                 && (LW'(idx_q) == (sd_len_q - LW'(1'b1)));
    end

    // FSM state register.
    always_ff @(posedge mem_clk or posedge ft_reset) begin
        if (ft_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dn_q) state_d = ST_COLLECT;
                else      state_d = ST_IDLE;
            end
            ST_COLLECT: begin
                if (flush_s) state_d = ST_REQ;
                else         state_d = ST_COLLECT;
            end
            ST_REQ: begin
                if (sd_gnt) state_d = ST_XFER;
                else        state_d = ST_REQ;
            end
            ST_XFER: begin
                if (last_s) state_d = ST_IDLE;
                else        state_d = ST_XFER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: base address, word count, burst index, timeout.
    always_comb begin
        base_d  = base_q;
        count_d = count_q;
        idx_d   = {IW{1'b0}};
        to_d    = {TW{1'b0}};

        if (ack_q && (count_q == {LW{1'b0}})) begin
            base_d = mem_wr_addr;
        end else begin
            base_d = base_q;
        end

        if (last_s) begin
            count_d = {LW{1'b0}};
        end else if (dn_q) begin
            count_d = count_q + LW'(1'b1);
        end else begin
            count_d = count_q;
        end

        if (state_q == ST_XFER) begin
            if (last_s) begin
                idx_d = {IW{1'b0}};
            end else if (sd_wdata_next) begin
                idx_d = idx_q + IW'(1'b1);
            end else begin
                idx_d = idx_q;
            end
        end else begin
            idx_d = {IW{1'b0}};
        end

        if (state_q == ST_COLLECT) begin
            if (dn_q) begin
                to_d = {TW{1'b0}};
            end else if (to_q != TW'(FLUSH_TIMEOUT)) begin
                to_d = to_q + TW'(1'b1);
            end else begin
                to_d = to_q;
            end
        end else begin
            to_d = {TW{1'b0}};
        end
    end

    // FSM output logic: next values of every registered output.
    always_comb begin
        ack_d      = can_take_s && !flush_s;
        dn_d       = ack_q;
        sd_req_d   = (state_d == ST_REQ);
        sd_addr_d  = sd_addr_q;
        sd_len_d   = sd_len_q;
        sd_wdata_d = {DW{1'b0}};

        if ((state_q != ST_REQ) && (state_d == ST_REQ)) begin
            sd_addr_d = base_q;
            sd_len_d  = count_q;
        end else begin
            sd_addr_d = sd_addr_q;
            sd_len_d  = sd_len_q;
        end

        if (state_d == ST_XFER) begin
            sd_wdata_d = buf_rdata_s;
        end else begin
            sd_wdata_d = {DW{1'b0}};
        end

        idle_d = (state_d == ST_IDLE) && (count_d == {LW{1'b0}}) && !dn_d;
    end

    // Datapath and output registers.
    always_ff @(posedge mem_clk or posedge ft_reset) begin
        if (ft_reset) begin
            count_q    <= {LW{1'b0}};
            idx_q      <= {IW{1'b0}};
            to_q       <= {TW{1'b0}};
            base_q     <= {AW{1'b0}};
            ack_q      <= 1'b0;
            dn_q       <= 1'b0;
            sd_req_q   <= 1'b0;
            sd_addr_q  <= {AW{1'b0}};
            sd_len_q   <= {LW{1'b0}};
            sd_wdata_q <= {DW{1'b0}};
            idle_q     <= 1'b1;
        end else begin
            count_q    <= count_d;
            idx_q      <= idx_d;
            to_q       <= to_d;
            base_q     <= base_d;
            ack_q      <= ack_d;
            dn_q       <= dn_d;
            sd_req_q   <= sd_req_d;
            sd_addr_q  <= sd_addr_d;
            sd_len_q   <= sd_len_d;
            sd_wdata_q <= sd_wdata_d;
            idle_q     <= idle_d;
        end
    end

    assign mem_ack       = ack_q;
    assign mem_data_next = dn_q;
    assign mem_idle      = idle_q;
    assign sd_req        = sd_req_q;
    assign sd_addr       = sd_addr_q;
    assign sd_len        = sd_len_q;
    assign sd_wdata      = sd_wdata_q;

endmodule
